tblink_call_dispatch: RTL

- Synthesizable, parametrised successor to the single-method call target.
- Accepts method-call requests from N_CHANNELS independent request ports and arbitrates between them round-robin.
- Queues accepted calls in a pending FIFO, executes one call per cycle from a small method table, and returns completions with channel/call-id tags on one response port.
- Sits between the tblink transport bridge and HDL-side method implementations; replaces the behavioural per-instance claim/complete loop.

---
 rtl/tblink_call_pkg.sv | 18 +
 rtl/tblink_call_dispatch_if.sv | 37 +++
 rtl/tblink_rr_arb.sv | 45 ++++
 rtl/tblink_call_dispatch.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/tblink_call_pkg.sv
// Shared method-id encoding for the call dispatcher and its testbench.
package tblink_call_pkg;

  localparam int METH_W = 4;

  typedef logic [METH_W-1:0] meth_t;

  localparam meth_t METH_INC  = 4'd0;
  localparam meth_t METH_DEC  = 4'd1;
  localparam meth_t METH_ECHO = 4'd2;
  localparam meth_t METH_ACC  = 4'd3;

  // True for ids that have an implementation in the method table.
  function automatic logic meth_known(input meth_t m);
    return (m <= METH_ACC);
  endfunction

endpackage

// File: rtl/tblink_call_dispatch_if.sv
// Request/response bundle between the tblink transport bridge (master) and the dispatcher (slave).
interface tblink_call_dispatch_if #(
  parameter int N_CHANNELS = 2,
  parameter int DEPTH      = 4,
  parameter int ID_W       = 8,
  parameter int DATA_W     = 32
);
  localparam int CH_W = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
  localparam int NP_W = $clog2(DEPTH + 1) + 1;

  logic [N_CHANNELS-1:0]                         req_valid;
  logic [N_CHANNELS-1:0]                         req_ready;
  logic [N_CHANNELS*ID_W-1:0]                    req_id;
  logic [N_CHANNELS*tblink_call_pkg::METH_W-1:0] req_method;
  logic [N_CHANNELS*DATA_W-1:0]                  req_arg;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [CH_W-1:0]   rsp_chan;
  logic [ID_W-1:0]   rsp_id;
  logic [DATA_W-1:0] rsp_rv;
  logic              rsp_err;

  logic [NP_W-1:0]   n_pending;
  logic              idle;

  modport master (
    output req_valid, req_id, req_method, req_arg, rsp_ready,
    input  req_ready, rsp_valid, rsp_chan, rsp_id, rsp_rv, rsp_err, n_pending, idle
  );

  modport slave (
    input  req_valid, req_id, req_method, req_arg, rsp_ready,
    output req_ready, rsp_valid, rsp_chan, rsp_id, rsp_rv, rsp_err, n_pending, idle
  );

endinterface

// File: rtl/tblink_rr_arb.sv
// N-way round-robin arbiter: search starts one past the last winner; the pointer moves only on advance.
module tblink_rr_arb #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [IDX_W-1:0] ptr;

  // Reset to the last channel so channel 0 is searched first.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= IDX_W'(N - 1);
    end else if (advance) begin
      ptr <= gnt_idx;
    end
  end

  always_comb begin
    int               cand;
    logic [IDX_W-1:0] ci;
    logic             found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = 0;
    ci      = '0;
    for (int i = 1; i <= N; i++) begin
      cand = (int'(ptr) + i) % N;
      ci   = IDX_W'(cand);
      if (!found && req[ci]) begin
        found   = 1'b1;
        gnt[ci] = 1'b1;
        gnt_idx = ci;
      end
    end
  end

endmodule

// File: rtl/tblink_call_dispatch.sv
// Arbitrates N request channels into a pending FIFO, executes one call per cycle, returns tagged completions.
// Accept-to-rsp_valid is 2 cycles when idle; req_ready falls only when the FIFO is full, never on rsp_ready.
module tblink_call_dispatch
  import tblink_call_pkg::*;
#(
  parameter int N_CHANNELS = 2,
  parameter int DEPTH      = 4,
  parameter int ID_W       = 8,
  parameter int DATA_W     = 32,
  parameter int INC_AMT    = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  tblink_call_dispatch_if.slave bus
);

  localparam int CH_W  = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int NP_W  = CNT_W + 1;

  typedef struct packed {
    logic [CH_W-1:0]   chan;
    logic [ID_W-1:0]   id;
    meth_t             method;
    logic [DATA_W-1:0] arg;
  } entry_t;

  logic [N_CHANNELS-1:0] gnt;
  logic [N_CHANNELS-1:0] ready;
  logic [CH_W-1:0]       gnt_idx;
  logic                  has_room;
  logic                  accept;
  logic                  load;

  logic [ID_W-1:0]   ch_id  [N_CHANNELS];
  meth_t             ch_meth[N_CHANNELS];
  logic [DATA_W-1:0] ch_arg [N_CHANNELS];

  entry_t            mem [DEPTH];
  entry_t            wr_ent;
  entry_t            head;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CNT_W-1:0]  count;

  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] acc_nxt;
  logic [DATA_W-1:0] exec_rv;
  logic              exec_err;

  logic              rsp_valid;
  logic [CH_W-1:0]   rsp_chan;
  logic [ID_W-1:0]   rsp_id;
  logic [DATA_W-1:0] rsp_rv;
  logic              rsp_err;
  logic [NP_W-1:0]   n_pending;

  for (genvar c = 0; c < N_CHANNELS; c++) begin : g_split
    assign ch_id[c]   = bus.req_id[c*ID_W +: ID_W];
    assign ch_meth[c] = bus.req_method[c*METH_W +: METH_W];
    assign ch_arg[c]  = bus.req_arg[c*DATA_W +: DATA_W];
  end

  tblink_rr_arb #(
    .N     (N_CHANNELS),
    .IDX_W (CH_W)
  ) u_arb (
    .clock   (clock),
    .reset   (reset),
    .req     (bus.req_valid),
    .advance (accept),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Room is judged on the registered count, so a same-cycle response pop does not reopen the gate.
  assign has_room = !reset && (count < CNT_W'(DEPTH));
  assign ready    = has_room ? gnt : '0;
  assign accept   = |(bus.req_valid & ready);
  assign load     = (count != '0) && (!rsp_valid || bus.rsp_ready);

  assign wr_ent.chan   = gnt_idx;
  assign wr_ent.id     = ch_id[gnt_idx];
  assign wr_ent.method = ch_meth[gnt_idx];
  assign wr_ent.arg    = ch_arg[gnt_idx];
  assign head          = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (accept) begin
      mem[wr_ptr] <= wr_ent;
    end
  end

  always_comb begin
    exec_rv  = '0;
    exec_err = !meth_known(head.method);
    acc_nxt  = acc;
    case (head.method)
      METH_INC:  exec_rv = head.arg + DATA_W'(INC_AMT);
      METH_DEC:  exec_rv = head.arg - DATA_W'(INC_AMT);
      METH_ECHO: exec_rv = head.arg;
      METH_ACC: begin
        acc_nxt = acc + head.arg;
        exec_rv = acc_nxt;
      end
      default:   exec_rv = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      acc       <= '0;
      rsp_valid <= 1'b0;
      rsp_chan  <= '0;
      rsp_id    <= '0;
      rsp_rv    <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (load) begin
        rd_ptr    <= rd_ptr + 1'b1;
        acc       <= acc_nxt;
        rsp_valid <= 1'b1;
        rsp_chan  <= head.chan;
        rsp_id    <= head.id;
        rsp_rv    <= exec_rv;
        rsp_err   <= exec_err;
      end else if (bus.rsp_ready) begin
        rsp_valid <= 1'b0;
      end
      case ({accept, load})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign n_pending = NP_W'(count) + NP_W'(rsp_valid);

  assign bus.req_ready = ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_chan  = rsp_chan;
  assign bus.rsp_id    = rsp_id;
  assign bus.rsp_rv    = rsp_rv;
  assign bus.rsp_err   = rsp_err;
  assign bus.n_pending = n_pending;
  assign bus.idle      = (n_pending == '0);

endmodule
